// File: rtl/fmlbrg_pkg.sv
// fmlbrg_pkg: shared FML bridge definitions.
// Contents:
//   FML_DW       FML data bus width (32)
//   FML_SEL_ALL  byte enables for a full-word burst beat (4'hf)
//   wb_state_t   write-back engine state encoding
//   line_adr_w() width of the FML line address {tag, index}
package fmlbrg_pkg;

    localparam int         FML_DW      = 32;
    localparam logic [3:0] FML_SEL_ALL = 4'hf;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REQ,
        BURST
    } wb_state_t;

    // A line address drops the word-in-line and byte-in-word bits of a byte address.
    function automatic int line_adr_w(int fml_depth, int lwords_log2);
        return fml_depth - lwords_log2 - 2;
    endfunction

endpackage

// File: rtl/fmlbrg_wbbuf.sv
// fmlbrg_wbbuf: N x 32 line buffer for the write-back engine.
// Ports:
//   sys_clk  system clock
//   we, wa   write strobe and word index (filled while fetching the line)
//   wd       write data
//   ra       read word index (walked while bursting)
//   rd       asynchronous read data
// Contents are deliberately not reset; every word is rewritten before it is read.
module fmlbrg_wbbuf
    import fmlbrg_pkg::*;
#(
    parameter int lwords_log2 = 3
) (
    input  logic                   sys_clk,
    input  logic                   we,
    input  logic [lwords_log2-1:0] wa,
    input  logic [FML_DW-1:0]      wd,
    input  logic [lwords_log2-1:0] ra,
    output logic [FML_DW-1:0]      rd
);

    logic [FML_DW-1:0] mem [0:(1 << lwords_log2)-1];

    always_ff @(posedge sys_clk) begin
        if (we)
            mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/fmlbrg_wbeng.sv
// fmlbrg_wbeng: evicts one dirty cache line from the bridge data memory to FML as a write burst.
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   start                one-cycle eviction request (honoured only when idle)
//   line_idx, line_adr   line index in data memory / FML line address, sampled with start
//   busy, done           engine occupied / one-cycle completion pulse
//   a2, do2              data memory secondary (read-only) port; do2 lags a2 by one cycle
//   fml_*                FML master write port, single N-beat burst per eviction
module fmlbrg_wbeng
    import fmlbrg_pkg::*;
#(
    parameter int depth       = 11,
    parameter int lwords_log2 = 3,
    parameter int fml_depth   = 26
) (
    input  logic                                           sys_clk,
    input  logic                                           sys_rst_n,
    input  logic                                           start,
    input  logic [depth-lwords_log2-1:0]                   line_idx,
    input  logic [line_adr_w(fml_depth, lwords_log2)-1:0]  line_adr,
    output logic                                           busy,
    output logic                                           done,
    output logic [depth-1:0]                               a2,
    input  logic [FML_DW-1:0]                              do2,
    output logic [fml_depth-1:0]                           fml_adr,
    output logic                                           fml_stb,
    output logic                                           fml_we,
    output logic [3:0]                                     fml_sel,
    input  logic                                           fml_ack,
    output logic [FML_DW-1:0]                              fml_do
);

    localparam int N = 1 << lwords_log2;
    localparam logic [lwords_log2:0]   CNT_ONE   = (lwords_log2+1)'(1);
    localparam logic [lwords_log2:0]   CNT_LAST  = (lwords_log2+1)'(N - 1);
    localparam logic [lwords_log2:0]   CNT_FETCH = (lwords_log2+1)'(N);
    localparam logic [lwords_log2-1:0] IDX_ONE   = lwords_log2'(1);

    wb_state_t                state;
    logic [depth-lwords_log2-1:0] line_idx_r;
    // One extra bit: FETCH runs N+1 cycles because do2 trails a2 by one.
    logic [lwords_log2:0]     cnt;
    logic [lwords_log2:0]     cnt_inc;
    logic                     buf_we;
    logic [lwords_log2-1:0]   buf_wa;
    logic [lwords_log2-1:0]   buf_ra;
    logic [FML_DW-1:0]        buf_rd;

    // In FETCH the word arriving on do2 belongs to the address issued last cycle (cnt-1).
    // The read port looks one beat ahead so fml_do can be registered.
    always_comb begin
        cnt_inc = cnt + CNT_ONE;
        buf_we  = (state == FETCH) && (cnt != '0);
        buf_wa  = cnt[lwords_log2-1:0] - IDX_ONE;
        buf_ra  = (state == BURST) ? cnt_inc[lwords_log2-1:0] : '0;
    end

    fmlbrg_wbbuf #(
        .lwords_log2 (lwords_log2)
    ) u_buf (
        .sys_clk (sys_clk),
        .we      (buf_we),
        .wa      (buf_wa),
        .wd      (do2),
        .ra      (buf_ra),
        .rd      (buf_rd)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            line_idx_r <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            a2         <= '0;
            fml_adr    <= '0;
            fml_stb    <= 1'b0;
            fml_we     <= 1'b0;
            fml_sel    <= 4'h0;
            fml_do     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        line_idx_r <= line_idx;
                        cnt        <= '0;
                        a2         <= {line_idx, {lwords_log2{1'b0}}};
                        fml_adr    <= {line_adr, {(lwords_log2+2){1'b0}}};
                    end
                end
                FETCH: begin
                    cnt <= cnt_inc;
                    // Stop advancing a2 after the last word; it then holds its value.
                    if (cnt < CNT_LAST)
                        a2 <= {line_idx_r, cnt_inc[lwords_log2-1:0]};
                    if (cnt == CNT_FETCH) begin
                        state   <= REQ;
                        cnt     <= '0;
                        fml_stb <= 1'b1;
                        fml_we  <= 1'b1;
                    end
                end
                REQ: begin
                    if (fml_ack) begin
                        state   <= BURST;
                        fml_stb <= 1'b0;
                        fml_we  <= 1'b0;
                        fml_sel <= FML_SEL_ALL;
                        fml_do  <= buf_rd;
                    end
                end
                BURST: begin
                    if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        fml_sel <= 4'h0;
                        fml_do  <= '0;
                    end else begin
                        cnt    <= cnt_inc;
                        fml_do <= buf_rd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmlbrg_wbeng.sv
// tb_fmlbrg_wbeng: scoreboard bench for the FML bridge write-back engine.
module tb_fmlbrg_wbeng;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  line_idx = '0;
    logic [20:0] line_adr = '0;
    logic        busy, done;
    logic [10:0] a2;
    logic [31:0] do2 = '0;
    logic [25:0] fml_adr;
    logic        fml_stb, fml_we;
    logic [3:0]  fml_sel;
    logic        fml_ack;
    logic [31:0] fml_do;

    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    assign fml_ack = resp_ack | spur_ack;

    fmlbrg_wbeng dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .line_idx  (line_idx),
        .line_adr  (line_adr),
        .busy      (busy),
        .done      (done),
        .a2        (a2),
        .do2       (do2),
        .fml_adr   (fml_adr),
        .fml_stb   (fml_stb),
        .fml_we    (fml_we),
        .fml_sel   (fml_sel),
        .fml_ack   (fml_ack),
        .fml_do    (fml_do)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Data memory: lines 2 and 3 hold A0000000.., everything else a distinct filler.
    logic [31:0] mem [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++)
            mem[i] = (i >= 16 && i < 32) ? 32'hA000_0000 + 32'(i - 16) : 32'h5A00_0000 + 32'(i);
    end
    always @(posedge sys_clk) do2 <= mem[a2];

    int checks = 0;
    int passes = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] adr_q[$];
    int done_cnt = 0;
    int beats = 0;
    int t_done = 0;
    int t_start = 0;
    int stb_run = 0;
    int last_stb_run = 0;
    int ack_delay = 0;

    // FML slave: acks after ack_delay extra strobe cycles.
    initial begin
        int stb_wait;
        stb_wait = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (fml_stb && !resp_ack) begin
                if (stb_wait >= ack_delay) begin
                    resp_ack = 1'b1;
                    stb_wait = 0;
                end else stb_wait++;
            end else begin
                resp_ack = 1'b0;
                stb_wait = 0;
            end
        end
    end

    // Monitor: compares requests and beats against the scoreboard queues.
    initial begin
        logic prev_stb;
        prev_stb = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) prev_stb = 1'b0;
            else begin
                if (fml_stb && !prev_stb) begin
                    stb_run = 1;
                    if (adr_q.size() == 0) chk("unexpected_req", 32'(fml_adr), 32'hffff_ffff);
                    else chk("fml_adr", 32'(fml_adr), adr_q.pop_front());
                    chk("fml_we", 32'(fml_we), 32'd1);
                end else if (fml_stb) stb_run++;
                if (!fml_stb && prev_stb) last_stb_run = stb_run;
                if (fml_sel != 4'h0) begin
                    beats++;
                    chk("beat_sel", 32'(fml_sel), 32'hf);
                    if (exp_q.size() == 0) chk("unexpected_beat", fml_do, 32'hdead_beef);
                    else chk("beat_data", fml_do, exp_q.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    t_done = cyc;
                    chk("done_do_zero", fml_do, 32'd0);
                    chk("done_busy_low", 32'(busy), 32'd0);
                end
                prev_stb = fml_stb;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] idx, input logic [20:0] adr,
                               input logic [31:0] base, input bit accept);
        @(posedge sys_clk);
        #1;
        start = 1'b1;
        line_idx = idx;
        line_adr = adr;
        if (accept) begin
            t_start = cyc;
            adr_q.push_back(32'({adr, 5'b0}));
            for (int k = 0; k < 8; k++) exp_q.push_back(base + 32'(k));
        end
        @(posedge sys_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            @(negedge sys_clk);
            #1;
        end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_beats(input int target, input int budget);
        for (int i = 0; i < budget && beats < target; i++) begin
            @(negedge sys_clk);
            #1;
        end
        chk("beats_reached", 32'(beats >= target), 32'd1);
    endtask

    initial begin
        int d0, b0;
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, b0;
        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stb", 32'(fml_stb), 0);
        chk("rst_we", 32'(fml_we), 0);
        chk("rst_sel", 32'(fml_sel), 0);
        chk("rst_adr", 32'(fml_adr), 0);
        chk("rst_do", fml_do, 0);
        chk("rst_a2", 32'(a2), 0);
        sys_rst_n = 1'b1;

        // Spurious ack while idle
        @(posedge sys_clk); #1;
        spur_ack = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            chk("idle_ack_stb", 32'(fml_stb), 0);
            chk("idle_ack_busy", 32'(busy), 0);
        end
        @(posedge sys_clk); #1;
        spur_ack = 1'b0;

        // Basic: line 2, ack 3 cycles after strobe
        ack_delay = 3;
        pulse_start(8'd2, 21'h01234, 32'hA000_0000, 1);
        chk("fetch_a2_word0", 32'(a2), 32'd16);
        chk("fetch_busy", 32'(busy), 1);
        wait_done(60);
        chk("basic_stb_len", 32'(last_stb_run), 4);
        chk("basic_latency", 32'(t_done - t_start), 22);

        // Immediate ack: best-case latency
        ack_delay = 0;
        pulse_start(8'd3, 21'h00042, 32'hA000_0008, 1);
        wait_done(60);
        chk("fast_latency", 32'(t_done - t_start), 19);
        chk("fast_stb_len", 32'(last_stb_run), 1);

        // Spurious ack during FETCH
        ack_delay = 1;
        pulse_start(8'd2, 21'h00abc, 32'hA000_0000, 1);
        spur_ack = 1'b1;
        repeat (4) begin
            @(negedge sys_clk);
            chk("fetch_ack_stb", 32'(fml_stb), 0);
        end
        @(posedge sys_clk); #1;
        spur_ack = 1'b0;
        wait_done(60);
        chk("spur_latency", 32'(t_done - t_start), 20);

        // start during FETCH and BURST is ignored
        ack_delay = 2;
        d0 = done_cnt;
        pulse_start(8'd4, 21'h1f0f0, 32'h5A00_0020, 1);
        pulse_start(8'd7, 21'h00001, 32'h0, 0);
        wait_beats(beats + 2, 60);
        pulse_start(8'd6, 21'h00002, 32'h0, 0);
        wait_done(60);
        repeat (30) @(negedge sys_clk);
        chk("ignored_done_cnt", 32'(done_cnt - d0), 1);
        chk("ignored_exp_empty", 32'(exp_q.size()), 0);
        chk("ignored_adr_empty", 32'(adr_q.size()), 0);

        // Reset during BURST beat 4
        ack_delay = 0;
        b0 = beats;
        pulse_start(8'd2, 21'h00555, 32'hA000_0000, 1);
        wait_beats(b0 + 5, 60);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_stb", 32'(fml_stb), 0);
        chk("midrst_sel", 32'(fml_sel), 0);
        chk("midrst_do", fml_do, 0);
        chk("midrst_a2", 32'(a2), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_left", 32'(exp_q.size()), 3);
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (25) @(negedge sys_clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        b0 = beats;
        pulse_start(8'd3, 21'h00777, 32'hA000_0008, 1);
        wait_done(60);
        chk("postrst_beats", 32'(beats - b0), 8);

        // Back-to-back: start in the done cycle
        b0 = beats;
        pulse_start(8'd2, 21'h00100, 32'hA000_0000, 1);
        wait_done(60);
        start = 1'b1;
        line_idx = 8'd3;
        line_adr = 21'h00200;
        t_start = cyc;
        adr_q.push_back(32'({21'h00200, 5'b0}));
        for (int k = 0; k < 8; k++) exp_q.push_back(32'hA000_0008 + 32'(k));
        @(posedge sys_clk); #1;
        start = 1'b0;
        wait_done(60);
        chk("b2b_latency", 32'(t_done - t_start), 19);
        chk("b2b_beats", 32'(beats - b0), 16);
        chk("b2b_exp_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
